// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_fetch_unit_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_fifo.sv
// Small synchronous FIFO with flush; head is read straight from the storage flops.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assert property (@(posedge clk) disable iff (!rst) !(do_push && full && !do_pop));
  assert property (@(posedge clk) disable iff (!rst) !(pop && empty && !flush));

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: issues in-order imem requests, tags returned words with
// their PC, buffers them for the core, and flushes/redirects on a taken branch.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = CW + 1;
  localparam int EW = $bits(fetch_entry_t);

  logic [31:0]   fetch_pc;
  logic [31:0]   last_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] drop;
  logic          resp;
  logic          handshake;
  logic          buf_push;
  logic          buf_pop;
  logic [SW-1:0] used;
  logic [SW-1:0] credit_limit;

  fetch_entry_t  buf_in;
  fetch_entry_t  buf_head;
  logic [EW-1:0] buf_head_bits;
  logic [CW-1:0] buf_count;
  logic          buf_empty;
  logic          buf_full;

  logic [31:0]   pcq_head;
  logic [CW-1:0] pcq_count;
  logic          pcq_empty;
  logic          pcq_full;

  // Stray rvalid with nothing in flight (e.g. straddling a reset) is ignored.
  assign resp      = imem_rvalid && (outstanding != '0);
  assign buf_pop   = !buf_empty && !stall && !branch_taken;
  assign handshake = imem_req && imem_gnt;

  // A head leaving this cycle frees its slot in time for the word a new request brings
  // back, which is what sustains one instruction per cycle with only two entries.
  assign used         = SW'(outstanding) + SW'(buf_count);
  assign credit_limit = SW'(FIFO_DEPTH) + SW'(buf_pop);
  assign imem_req     = rst && !branch_taken && (used < credit_limit);
  assign imem_addr    = fetch_pc;

  assign outstanding_next = outstanding + CW'(handshake) - CW'(resp);
  assign buf_push         = resp && (drop == '0) && !branch_taken;

  always_comb begin
    buf_in      = '0;
    buf_in.pc   = pcq_head;
    buf_in.inst = imem_rdata;
  end

  assign buf_head   = fetch_entry_t'(buf_head_bits);
  assign inst_valid = !buf_empty;
  assign pc         = buf_empty ? last_pc : buf_head.pc;
  assign inst       = buf_empty ? NOP_INST : buf_head.inst;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      last_pc     <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (!buf_empty) last_pc <= buf_head.pc;
      if (branch_taken) begin
        fetch_pc <= word_align(branch_addr);
        drop     <= outstanding_next;
      end else begin
        if (handshake) fetch_pc <= fetch_pc + 32'd4;
        if (resp && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (handshake),
    .push_data (fetch_pc),
    .pop       (resp),
    .head      (pcq_head),
    .count     (pcq_count),
    .empty     (pcq_empty),
    .full      (pcq_full)
  );

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_inst_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (branch_taken),
    .push      (buf_push),
    .push_data (buf_in),
    .pop       (buf_pop),
    .head      (buf_head_bits),
    .count     (buf_count),
    .empty     (buf_empty),
    .full      (buf_full)
  );

  assert property (@(posedge clk) disable iff (!rst) outstanding <= CW'(FIFO_DEPTH));
  assert property (@(posedge clk) disable iff (!rst) drop <= outstanding);
  assert property (@(posedge clk) disable iff (!rst) pcq_count == outstanding);
  assert property (@(posedge clk) disable iff (!rst) !(resp && pcq_empty));
  assert property (@(posedge clk) disable iff (!rst) !(handshake && pcq_full));
  assert property (@(posedge clk) disable iff (!rst) !(buf_push && buf_full && !buf_pop));

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with an in-order imem model returning addr-as-data.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_addr = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid;

  logic        gnt_en = 1'b1;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        inj_valid = 1'b0;
  logic [31:0] inj_data = 32'h0;
  int          lat = 1;
  int          cyc = 0;
  logic [31:0] q_addr[$];
  int          q_due[$];

  int checks = 0;
  int errors = 0;

  if_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .pc           (pc),
    .inst         (inst),
    .inst_valid   (inst_valid)
  );

  always #5 clk = ~clk;

  assign imem_gnt    = gnt_en;
  assign imem_rvalid = mem_rvalid | inj_valid;
  assign imem_rdata  = inj_valid ? inj_data : mem_rdata;

  // Memory model: record handshakes mid-cycle, answer in order lat cycles later.
  always @(negedge clk) begin
    if (!rst) begin
      q_addr.delete();
      q_due.delete();
    end else if (imem_req && imem_gnt) begin
      q_addr.push_back(imem_addr);
      q_due.push_back(cyc + lat);
    end
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    if (q_addr.size() > 0 && q_due[0] <= cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = q_addr.pop_front();
      void'(q_due.pop_front());
    end else begin
      mem_rvalid = 1'b0;
    end
  end

  typedef struct {
    logic        restart;
    logic        stall;
    logic        gnt;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic s, logic g, logic er, logic [31:0] ea,
                              logic ev, logic [31:0] ep);
    vec_t v;
    v.restart = r; v.stall = s; v.gnt = g;
    v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    gnt_en = 1'b1;
    inj_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max_cycles, output int waited);
    waited = -1;
    for (int k = 0; k < max_cycles; k++) begin
      @(negedge clk);
      if (inst_valid) begin
        waited = k;
        break;
      end
      next_cycle();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;

    // Stream from reset, then a 5-cycle stall (cycles 5..9).
    vq.push_back(mk(1, 0, 1, 1, 32'h00, 0, 32'h00));
    vq.push_back(mk(0, 0, 1, 1, 32'h04, 0, 32'h00));
    vq.push_back(mk(0, 0, 1, 1, 32'h08, 1, 32'h00));
    vq.push_back(mk(0, 0, 1, 1, 32'h0C, 1, 32'h04));
    vq.push_back(mk(0, 0, 1, 1, 32'h10, 1, 32'h08));
    for (int i = 0; i < 5; i++) vq.push_back(mk(0, 1, 1, 0, 32'h14, 1, 32'h0C));
    vq.push_back(mk(0, 0, 1, 1, 32'h14, 1, 32'h0C));
    vq.push_back(mk(0, 0, 1, 1, 32'h18, 1, 32'h10));
    vq.push_back(mk(0, 0, 1, 1, 32'h1C, 1, 32'h14));
    vq.push_back(mk(0, 0, 1, 1, 32'h20, 1, 32'h18));
    // Grant withheld for 4 cycles (cycles 2..5).
    vq.push_back(mk(1, 0, 1, 1, 32'h00, 0, 32'h00));
    vq.push_back(mk(0, 0, 1, 1, 32'h04, 0, 32'h00));
    vq.push_back(mk(0, 0, 0, 1, 32'h08, 1, 32'h00));
    vq.push_back(mk(0, 0, 0, 1, 32'h08, 1, 32'h04));
    vq.push_back(mk(0, 0, 0, 1, 32'h08, 0, 32'h04));
    vq.push_back(mk(0, 0, 0, 1, 32'h08, 0, 32'h04));
    vq.push_back(mk(0, 0, 1, 1, 32'h08, 0, 32'h04));
    vq.push_back(mk(0, 0, 1, 1, 32'h0C, 0, 32'h04));
    vq.push_back(mk(0, 0, 1, 1, 32'h10, 1, 32'h08));

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, NOP_INST);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    $display("reset req=%b addr=%h pc=%h inst=%h valid=%b", imem_req, imem_addr, pc, inst, inst_valid);

    lat = 1;
    for (int i = 0; i < vq.size(); i++) begin
      if (vq[i].restart) do_reset();
      stall  = vq[i].stall;
      gnt_en = vq[i].gnt;
      @(negedge clk);
      chk($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vq[i].exp_req));
      chk($sformatf("vec%0d_addr", i), imem_addr, vq[i].exp_addr);
      chk($sformatf("vec%0d_valid", i), 32'(inst_valid), 32'(vq[i].exp_valid));
      chk($sformatf("vec%0d_pc", i), pc, vq[i].exp_pc);
      chk($sformatf("vec%0d_inst", i), inst, vq[i].exp_valid ? vq[i].exp_pc : NOP_INST);
      $display("vec %0d stall=%b gnt=%b req=%b addr=%h valid=%b pc=%h inst=%h",
               i, stall, gnt_en, imem_req, imem_addr, inst_valid, pc, inst);
      next_cycle();
    end

    // Redirect with two words in flight, 3-cycle read latency, unaligned target.
    lat = 3;
    do_reset();
    next_cycle();
    next_cycle();
    branch_taken = 1'b1;
    branch_addr  = 32'h0000_0102;
    @(negedge clk);
    chk("br_req_c2", 32'(imem_req), 32'h0);
    next_cycle();
    branch_taken = 1'b0;
    @(negedge clk);
    chk("br_req_c3", 32'(imem_req), 32'h0);
    chk("br_valid_c3", 32'(inst_valid), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("br_req_c4", 32'(imem_req), 32'h1);
    chk("br_addr_c4", imem_addr, 32'h100);
    chk("br_valid_c4", 32'(inst_valid), 32'h0);
    next_cycle();
    wait_valid(10, w);
    chk("br_wait", 32'(w), 32'd3);
    chk("br_pc", pc, 32'h100);
    chk("br_inst", inst, 32'h100);
    $display("redirect waited=%0d pc=%h inst=%h", w, pc, inst);

    // Redirect, stall and rvalid all in the same cycle.
    lat = 1;
    do_reset();
    repeat (4) @(posedge clk);
    #1;
    stall        = 1'b1;
    branch_taken = 1'b1;
    branch_addr  = 32'h0000_0200;
    @(negedge clk);
    chk("bs_req", 32'(imem_req), 32'h0);
    chk("bs_valid", 32'(inst_valid), 32'h1);
    chk("bs_pc", pc, 32'h8);
    chk("bs_rvalid", 32'(imem_rvalid), 32'h1);
    next_cycle();
    stall        = 1'b0;
    branch_taken = 1'b0;
    @(negedge clk);
    chk("bs_valid_c5", 32'(inst_valid), 32'h0);
    chk("bs_pc_c5", pc, 32'h8);
    chk("bs_req_c5", 32'(imem_req), 32'h1);
    chk("bs_addr_c5", imem_addr, 32'h200);
    next_cycle();
    @(negedge clk);
    chk("bs_valid_c6", 32'(inst_valid), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("bs_valid_c7", 32'(inst_valid), 32'h1);
    chk("bs_pc_c7", pc, 32'h200);
    chk("bs_inst_c7", inst, 32'h200);
    $display("branch+stall pc=%h inst=%h valid=%b", pc, inst, inst_valid);

    // Reset mid-stream, then a stray rvalid with nothing outstanding.
    lat = 1;
    do_reset();
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("mr_req", 32'(imem_req), 32'h0);
    chk("mr_addr", imem_addr, 32'h0);
    chk("mr_pc", pc, 32'h0);
    chk("mr_inst", inst, NOP_INST);
    chk("mr_valid", 32'(inst_valid), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    gnt_en    = 1'b0;
    inj_valid = 1'b1;
    inj_data  = 32'hDEAD_BEEF;
    rst       = 1'b1;
    @(negedge clk);
    chk("mr_valid_c0", 32'(inst_valid), 32'h0);
    chk("mr_req_c0", 32'(imem_req), 32'h1);
    chk("mr_addr_c0", imem_addr, 32'h0);
    next_cycle();
    inj_valid = 1'b0;
    gnt_en    = 1'b1;
    @(negedge clk);
    chk("mr_valid_c1", 32'(inst_valid), 32'h0);
    chk("mr_inst_c1", inst, NOP_INST);
    next_cycle();
    wait_valid(10, w);
    chk("mr_wait", 32'(w), 32'd1);
    chk("mr_pc_first", pc, 32'h0);
    chk("mr_inst_first", inst, 32'h0);
    $display("mid-reset restart waited=%0d pc=%h inst=%h", w, pc, inst);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
